cam_dta_generator: RTL and testbench



---
 rtl/cam_dta_generator.sv | 198 +++++++++++++++++++
 tb/tb_cam_dta_generator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cam_dta_generator.sv
`default_nettype none
// ============================================================================
// Module   : cam_dta_generator
// Purpose  : DVP camera-side byte source: RGB565 pixels sent low byte first
//            with href/vsync framing, fed externally or from test patterns.
// Revision : 1.0  initial release
// ============================================================================
module cam_dta_generator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 17,
    parameter int V_FP        = 10
) (
    input  logic        i_pclk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  CAM_DTA,
    output logic        href,
    output logic        vsync,
    output logic        busy,
    output logic        frame_done,
    output logic        underflow
);

    localparam int LINE_CYCLES = 2*H_ACTIVE + H_BLANK;
    localparam int ACT_BYTES   = 2*H_ACTIVE;
    localparam int HW          = $clog2(LINE_CYCLES);
    localparam int MAXL_A      = (VSYNC_LINES > V_BP) ? VSYNC_LINES : V_BP;
    localparam int MAXL_B      = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
    localparam int MAXL        = (MAXL_A > MAXL_B) ? MAXL_A : MAXL_B;
    localparam int VW          = $clog2(MAXL + 1);
    localparam int BAR_W       = H_ACTIVE / 8;
    localparam int BW          = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [1:0]      mode_q, mode_d;
    logic [2:0]      bar_q, bar_d, eff_bar;
    logic [BW-1:0]   bar_cnt_q, bar_cnt_d, eff_cnt;
    logic [7:0]      hi_q;
    logic [7:0]      cam_dta_q;
    logic            href_q, vsync_q, busy_q, frame_done_q, underflow_q;
    logic            line_end, state_end, frame_end, restart;
    logic            active_d, low_d, underflow_d;
    logic [15:0]     pixel;

    function automatic logic [VW-1:0] last_line(input state_t s);
        case (s)
            S_VSYNC:  last_line = VW'(VSYNC_LINES - 1);
            S_VBP:    last_line = VW'(V_BP - 1);
            S_ACTIVE: last_line = VW'(V_ACTIVE - 1);
            S_VFP:    last_line = VW'(V_FP - 1);
            default:  last_line = '0;
        endcase
    endfunction

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 16'hFFFF;
            3'd1:    bar_colour = 16'hFFE0;
            3'd2:    bar_colour = 16'h07FF;
            3'd3:    bar_colour = 16'h07E0;
            3'd4:    bar_colour = 16'hF81F;
            3'd5:    bar_colour = 16'hF800;
            3'd6:    bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    endfunction

    // Position of the next cycle; outputs are registered from this position.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        restart   = 1'b0;
        line_end  = (h_q == HW'(LINE_CYCLES - 1));
        state_end = line_end && (v_q == last_line(state_q));
        frame_end = state_end &&
                    ((state_q == S_VFP) || ((state_q == S_ACTIVE) && (V_FP == 0)));
        if (state_q == S_IDLE) begin
            restart = start;
        end else if (line_end) begin
            h_d = '0;
            if (state_end) begin
                v_d = '0;
                case (state_q)
                    S_VSYNC: begin
                        if (V_BP > 0) state_d = S_VBP;
                        else          state_d = S_ACTIVE;
                    end
                    S_VBP:   state_d = S_ACTIVE;
                    S_ACTIVE: begin
                        if (V_FP > 0) state_d = S_VFP;
                        else          state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
                restart = frame_end && start;
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
        end
        if (restart) begin
            h_d = '0;
            v_d = '0;
            if (VSYNC_LINES > 0)  state_d = S_VSYNC;
            else if (V_BP > 0)    state_d = S_VBP;
            else                  state_d = S_ACTIVE;
        end
        mode_d = restart ? mode : mode_q;
    end

    // Frame starts and ends are excluded so pix_ready never depends on start.
    always_comb begin
        active_d  = (state_d == S_ACTIVE) && (h_d < HW'(ACT_BYTES));
        low_d     = active_d && !h_d[0];
        pix_ready = (mode_q == 2'd0) && (state_q != S_IDLE) && !frame_end && low_d;
        eff_bar   = (h_d == '0) ? 3'd0 : bar_q;
        eff_cnt   = (h_d == '0) ? '0 : bar_cnt_q;
        if (eff_cnt == BW'(BAR_W - 1)) begin
            bar_cnt_d = '0;
            bar_d     = eff_bar + 3'd1;
        end else begin
            bar_cnt_d = eff_cnt + BW'(1);
            bar_d     = eff_bar;
        end
        case (mode_d)
            2'd0:    pixel = (pix_ready && pix_valid) ? pix_in : 16'h0000;
            2'd1:    pixel = bar_colour(eff_bar);
            default: pixel = {8'(v_d), 8'(h_d >> 1)};
        endcase
        underflow_d = pix_ready && !pix_valid;
    end

    always_ff @(posedge i_pclk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            mode_q       <= 2'd0;
            bar_q        <= 3'd0;
            bar_cnt_q    <= '0;
            hi_q         <= 8'd0;
            cam_dta_q    <= 8'd0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            mode_q       <= mode_d;
            href_q       <= active_d;
            vsync_q      <= (state_d == S_IDLE) || (state_d == S_VSYNC);
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= frame_end;
            underflow_q  <= underflow_d;
            if (low_d) begin
                cam_dta_q <= pixel[7:0];
                hi_q      <= pixel[15:8];
                bar_q     <= bar_d;
                bar_cnt_q <= bar_cnt_d;
            end else if (active_d) begin
                cam_dta_q <= hi_q;
            end else begin
                cam_dta_q <= 8'd0;
            end
        end
    end

    assign CAM_DTA    = cam_dta_q;
    assign href       = href_q;
    assign vsync      = vsync_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_dta_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_dta_generator
// Purpose  : Randomized bench for cam_dta_generator against a frame-position
//            reference model (cycle index within frame -> expected outputs).
// Revision : 1.0  initial release
// ============================================================================
module tb_cam_dta_generator;

    localparam int HA    = 16;
    localparam int HB    = 3;
    localparam int VA    = 3;
    localparam int VS    = 1;
    localparam int VBP   = 1;
    localparam int VFP   = 1;
    localparam int LC    = 2*HA + HB;
    localparam int FRAME = (VS + VBP + VA + VFP) * LC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] pix_in = 16'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  CAM_DTA;
    logic        href, vsync, busy, frame_done, underflow;

    cam_dta_generator #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BP(VBP), .V_FP(VFP)
    ) dut (
        .i_pclk(clk), .reset(rst_n), .start(start), .mode(mode),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .CAM_DTA(CAM_DTA), .href(href), .vsync(vsync), .busy(busy),
        .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // Model: whether a frame runs, and the cycle index inside it.
    bit         m_busy;
    int         m_t;
    logic [1:0] m_mode;
    logic [7:0] m_hi;
    logic [7:0] e_dta;
    bit         e_href, e_vsync, e_busy, e_fd, e_uf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit in_active(input int t);
        int line = t / LC;
        int h    = t % LC;
        return (line >= VS + VBP) && (line < VS + VBP + VA) && (h < 2*HA);
    endfunction

    function automatic bit exp_ready();
        return m_busy && (m_mode == 2'd0) && (m_t + 1 < FRAME) &&
               in_active(m_t + 1) && (((m_t + 1) % LC) % 2 == 0);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_mode = 2'd0; m_hi = 8'd0;
        e_dta = 8'd0; e_href = 0; e_vsync = 1; e_busy = 0; e_fd = 0; e_uf = 0;
    endtask

    task automatic model_edge(input bit pr);
        bit          end_e;
        int          line, h, pi, li;
        logic [15:0] px;
        end_e = m_busy && (m_t == FRAME - 1);
        e_fd  = end_e;
        e_uf  = pr && !pix_valid;
        if (!m_busy || end_e) begin
            if (start) begin
                m_busy = 1; m_t = 0; m_mode = mode;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_t++;
        end
        e_busy = m_busy;
        if (!m_busy) begin
            e_vsync = 1; e_href = 0; e_dta = 8'd0;
        end else begin
            line    = m_t / LC;
            h       = m_t % LC;
            e_vsync = (line < VS);
            e_href  = in_active(m_t);
            if (!e_href) begin
                e_dta = 8'd0;
            end else if (h % 2 == 1) begin
                e_dta = m_hi;
            end else begin
                pi = h / 2;
                li = line - VS - VBP;
                case (m_mode)
                    2'd0:    px = (pr && pix_valid) ? pix_in : 16'h0000;
                    2'd1:    px = bars[pi / (HA / 8)];
                    default: px = {8'(li), 8'(pi)};
                endcase
                e_dta = px[7:0];
                m_hi  = px[15:8];
            end
        end
    endtask

    task automatic check_outputs();
        check("CAM_DTA",    CAM_DTA,    e_dta);
        check("href",       href,       e_href);
        check("vsync",      vsync,      e_vsync);
        check("busy",       busy,       e_busy);
        check("frame_done", frame_done, e_fd);
        check("underflow",  underflow,  e_uf);
    endtask

    task automatic drive(input int start_pct);
        start     = ($urandom_range(0, 99) < start_pct);
        mode      = 2'($urandom_range(0, 3));
        pix_valid = ($urandom_range(0, 9) != 0);
        pix_in    = 16'($urandom);
    endtask

    task automatic step();
        bit pr;
        pr = exp_ready();
        check("pix_ready", pix_ready, pr);
        @(posedge clk);
        model_edge(pr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int cycles, input int start_pct);
        for (int i = 0; i < cycles; i++) begin
            drive(start_pct);
            step();
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs();
        check("pix_ready_rst", pix_ready, 1'b0);
        rst_n = 1'b1;

        run(30, 0);
        run(1500, 5);
        run(3*FRAME + 20, 100);

        for (int i = 0; i < FRAME + 5 && m_busy; i++) begin
            drive(0);
            step();
        end
        drive(0);
        start = 1'b1;
        mode  = 2'd0;
        step();
        run((VS + VBP) * LC + 10, 0);

        // Asynchronous reset mid-line: outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("pix_ready_midrst", pix_ready, 1'b0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        run(1200, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
